// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter: FSM state
// encoding, frame constants, command bytes and the parity helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // A host frame spans 11 device clocks: 10 shifted bits plus the ACK clock
  localparam int FRAME_CLOCKS = 11;
  localparam int SHIFT_BITS   = FRAME_CLOCKS - 1;
  localparam int ACK_INDEX    = 11;

  // Common mouse commands
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Odd parity over a data byte
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_sync.sv
// ============================================================================
// ps2_clk_sync
// Two-flop synchronizers for the PS/2 clock and data pads plus a registered
// falling-edge strobe on the clock. Shared with the PS/2 packet receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_clk_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_meta;
  logic clk_hist;
  logic data_meta;

  // Synchronizer chains; idle lines are high, so reset to 1 to avoid a false edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_hist  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= clk_in;
      clk_sync  <= clk_meta;
      clk_hist  <= clk_sync;
      data_meta <= data_in;
      data_sync <= data_meta;
    end
  end

  // Registered falling-edge strobe: pad edge to strobe is three clk cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall <= 1'b0;
    end else begin
      fall <= clk_hist & ~clk_sync;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// bit shifting on device clock falls, odd parity, ACK check and timeout.
// Drives the open-drain pads through output-enable pins.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       SEND_LAST = 4'(SHIFT_BITS - 1);

  // The inhibit window must cover at least 100 us of the system clock
  if (longint'(INHIBIT_CYCLES) * 64'd10_000 < longint'(CLK_FREQ_HZ)) begin : g_inhibit_check
    $error("INHIBIT_CYCLES shorter than 100 us at CLK_FREQ_HZ");
  end

  logic clk_sync;
  logic data_sync;
  logic fall;

  ps2_clk_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .fall      (fall)
  );

  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [9:0]       shreg,   shreg_n;
  logic             ack_err, ack_err_n;
  logic             clk_oe_n, data_oe_n, busy_n, done_n, err_n;
  logic             in_timed_state;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      ack_err     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      ack_err     <= ack_err_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end

  // Next-state logic; line enables are computed one cycle ahead and registered
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    bit_idx_n      = bit_idx;
    shreg_n        = shreg;
    ack_err_n      = ack_err;
    clk_oe_n       = 1'b0;
    data_oe_n      = ps2_data_oe;
    done_n         = 1'b0;
    err_n          = tx_err;
    in_timed_state = 1'b0;

    case (state)
      ST_IDLE: begin
        data_oe_n = 1'b0;
        if (tx_start) begin
          shreg_n   = {1'b1, odd_parity(tx_data), tx_data};
          cnt_n     = '0;
          bit_idx_n = '0;
          ack_err_n = 1'b0;
          err_n     = 1'b0;
          clk_oe_n  = 1'b1;
          state_n   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        if (cnt == INH_LAST) begin
          // Enter REQ: clock still low, data pulled low as the start bit
          cnt_n     = '0;
          data_oe_n = 1'b1;
          state_n   = ST_REQ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_REQ: begin
        in_timed_state = 1'b1;
        cnt_n          = cnt + 1'b1;
        data_oe_n      = 1'b1;
        state_n        = ST_SEND;
      end

      ST_SEND: begin
        in_timed_state = 1'b1;
        cnt_n          = cnt + 1'b1;
        if (fall) begin
          data_oe_n = ~shreg[0];
          shreg_n   = {1'b0, shreg[9:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == SEND_LAST) begin
            state_n = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        in_timed_state = 1'b1;
        cnt_n          = cnt + 1'b1;
        data_oe_n      = 1'b0;
        if (fall) begin
          ack_err_n = data_sync;
          bit_idx_n = 4'(ACK_INDEX);
          state_n   = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        in_timed_state = 1'b1;
        cnt_n          = cnt + 1'b1;
        data_oe_n      = 1'b0;
        if (clk_sync && data_sync) begin
          done_n  = 1'b1;
          err_n   = ack_err;
          state_n = ST_IDLE;
        end
      end

      default: begin
        data_oe_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase

    // Timeout overrides everything once the device has been asked to clock
    if (in_timed_state && (cnt == TO_LAST)) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      done_n    = 1'b1;
      err_n     = 1'b1;
      state_n   = ST_IDLE;
    end

    busy_n = (state_n != ST_IDLE) || done_n;
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// tb_ps2_host_tx
// Self-checking bench: device model clocks frames, scoreboard holds expected
// frame bits and completion status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
  logic       ps2_clk_pad, ps2_data_pad;

  // Open-drain wired-AND of host and device on each line
  assign ps2_clk_pad  = ~ps2_clk_oe  & dev_clk;
  assign ps2_data_pad = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .CLK_FREQ_HZ    (100_000),
    .INHIBIT_CYCLES (10),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_pad),
    .ps2_data_in (ps2_data_pad),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic exp_bits[$];
  logic exp_err_q[$];

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       err;
    logic       dbl;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push expectations, issue the request and measure the inhibit/REQ window
  task automatic start_frame(input logic [7:0] d, input logic par, input logic err_exp,
                             input logic dbl);
    int k;
    int hi;
    int rise;
    for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
    exp_err_q.push_back(err_exp);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
    check("busy_after_accept", tx_busy, 1);
    k = 1; hi = 0; rise = 0;
    while (ps2_clk_oe && k < 100) begin
      hi++;
      if (ps2_data_oe && rise == 0) rise = k;
      if (dbl && k == 5) begin
        tx_start = 1'b1;
        tx_data  = 8'h12;
      end
      if (dbl && k == 6) tx_start = 1'b0;
      @(negedge clk);
      k++;
    end
    tx_start = 1'b0;
    check("clk_oe_cycles", hi, 11);
    check("data_oe_rise", rise, 11);
    check("start_bit_held", ps2_data_oe, 1);
  endtask

  // Device model: clocks 10 bits, then ACK clock; optional reset abort at a bit
  task automatic run_device(input logic ack, input int rst_bit);
    logic s;
    logic e;
    int   n;
    int   seen;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      if (i == rst_bit) begin
        check("data_oe_before_rst", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("clk_oe_on_rst", ps2_clk_oe, 0);
        check("data_oe_on_rst", ps2_data_oe, 0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
          @(negedge clk);
          if (tx_done) seen = 1;
        end
        check("no_done_after_rst", seen, 0);
        check("idle_after_rst", tx_busy, 0);
        exp_bits.delete();
        exp_err_q.delete();
        return;
      end
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
      s = ps2_data_pad;
      check("sb_bit_avail", exp_bits.size() > 0, 1);
      if (exp_bits.size() > 0) begin
        e = exp_bits.pop_front();
        check($sformatf("frame_bit%0d", i), s, e);
      end
      repeat (20) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    if (ack) dev_data = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    n = 0;
    while (!tx_done && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 5) dev_data = 1'b1;
    end
    dev_data = 1'b1;
    check("done_seen", tx_done, 1);
    e = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'bx;
    check("tx_err", tx_err, e);
    check("busy_at_done", tx_busy, 1);
    @(negedge clk);
    check("busy_after_done", tx_busy, 0);
    check("done_one_cycle", tx_done, 0);
    check("err_holds", tx_err, e);
  endtask

  initial begin
    int k;
    int n;
    vecs[0] = '{data: PS2_CMD_ENABLE, ack: 1'b1, par: 1'b0, err: 1'b0, dbl: 1'b0};
    vecs[1] = '{data: PS2_CMD_RESET,  ack: 1'b1, par: 1'b1, err: 1'b0, dbl: 1'b0};
    vecs[2] = '{data: 8'h00,          ack: 1'b0, par: 1'b1, err: 1'b1, dbl: 1'b0};
    vecs[3] = '{data: PS2_CMD_ENABLE, ack: 1'b1, par: 1'b0, err: 1'b0, dbl: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_clk_oe",  ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy",    tx_busy, 0);
    check("rst_done",    tx_done, 0);
    check("rst_err",     tx_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].data, vecs[i].par, vecs[i].err, vecs[i].dbl);
      run_device(vecs[i].ack, -1);
      repeat (5) @(negedge clk);
    end

    // Reset during bit 4, then a clean send
    start_frame(PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b0);
    run_device(1'b1, 3);
    start_frame(PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b0);
    run_device(1'b1, -1);
    repeat (5) @(negedge clk);

    // Silent device: timeout counted from the REQ cycle
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    k = 1;
    while (!ps2_data_oe && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("to_req_cycle", k, 11);
    n = 0;
    while (!tx_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 2000);
    check("to_clk_oe",  ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    check("to_done",    tx_done, 1);
    check("to_err",     tx_err, 1);
    @(negedge clk);
    check("to_busy_after", tx_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
